// File: rtl/dma_ib_arbiter.sv
// dma_ib_arbiter: frame-atomic round-robin arbiter for the DMA0 inbound stream.
// Each frame is tagged with its source index in dma_dest. Frame statistics
// are kept for the register map.
// Optional feature macro: DMA_ARB_TIMEOUT_EN adds a stall watchdog that
// force-terminates a frame whose source goes quiet for TIMEOUT cycles.
//
// Handshake: a beat moves across an interface in a cycle where valid and
// ready are both high at the rising edge of dmaClk. A valid beat holds its
// payload until it is taken. The output stage loads a new beat whenever it is
// empty or its current beat is being taken (slot_free).
module dma_ib_arbiter #(
  parameter int NUM_SRC = 2,
  parameter int TIMEOUT = 4096
) (
  input  logic                   dmaClk,
  input  logic                   dmaRst,
  input  logic [NUM_SRC-1:0]     src_valid,
  input  logic [64*NUM_SRC-1:0]  src_data,
  input  logic [NUM_SRC-1:0]     src_done,
  output logic [NUM_SRC-1:0]     src_ready,
  input  logic [NUM_SRC-1:0]     enable_mask,
  output logic                   dma_valid,
  output logic [63:0]            dma_data,
  output logic                   dma_done,
  output logic [7:0]             dma_dest,
  output logic                   dma_err,
  input  logic                   dma_ready,
  output logic [2:0]             grant_idx,
  output logic                   busy,
  output logic [31:0]            frame_count,
  output logic [15:0]            timeout_count
);

  localparam int GW = $clog2(NUM_SRC);

`ifdef DMA_ARB_TIMEOUT_EN
  typedef enum logic [1:0] {IDLE, XFER, TERM} state_t;
  localparam int CW = $clog2(TIMEOUT + 1);
  logic [CW-1:0] stall_cnt;
  logic          stall_hit;
  logic          ld_err;
  logic          term_inc;
  logic          err_q;
  logic [15:0]   tcnt_q;
`else
  typedef enum logic {IDLE, XFER} state_t;
`endif

  state_t          state, state_next;
  logic [GW-1:0]   grant, grant_next, pick, rr_idx;
  logic            found;
  logic [NUM_SRC-1:0] req;
  logic            slot_free, accept;
  logic            cur_valid, cur_done;
  logic [63:0]     cur_data;
  logic            ld_valid, ld_done, frame_inc;
  logic [63:0]     ld_data;

  assign req       = src_valid & enable_mask;
  assign slot_free = ~dma_valid | dma_ready;
  assign cur_valid = src_valid[grant];
  assign cur_done  = src_done[grant];
  assign cur_data  = src_data[int'(grant)*64 +: 64];
  assign accept    = (state == XFER) & cur_valid & slot_free;
  assign busy      = (state != IDLE);
  assign grant_idx = 3'(grant);

`ifdef DMA_ARB_TIMEOUT_EN
  assign stall_hit     = (stall_cnt == CW'(TIMEOUT - 1)) & ~cur_valid;
  assign dma_err       = err_q;
  assign timeout_count = tcnt_q;
`else
  assign dma_err       = 1'b0;
  assign timeout_count = '0;
`endif

  // Round-robin search: first requester after the last grant, wrapping.
  always_comb begin
    found  = 1'b0;
    pick   = grant;
    rr_idx = '0;
    for (int k = 1; k <= NUM_SRC; k++) begin
      rr_idx = GW'((int'(grant) + k) % NUM_SRC);
      if (!found && req[rr_idx]) begin
        found = 1'b1;
        pick  = rr_idx;
      end
    end
  end

  // Only the granted source sees ready, and only when the output slot frees.
  always_comb begin
    src_ready = '0;
    if (state == XFER) src_ready[grant] = cur_valid & slot_free;
  end

  // Next-state and output-stage load decode.
  always_comb begin
    state_next = state;
    grant_next = grant;
    ld_valid   = 1'b0;
    ld_data    = cur_data;
    ld_done    = cur_done;
    frame_inc  = 1'b0;
`ifdef DMA_ARB_TIMEOUT_EN
    ld_err     = 1'b0;
    term_inc   = 1'b0;
`endif
    case (state)
      IDLE: begin
        if (found) begin
          grant_next = pick;
          state_next = XFER;
        end
      end
      XFER: begin
        if (accept) begin
          ld_valid = 1'b1;
          if (cur_done) begin
            frame_inc  = 1'b1;
            state_next = IDLE;
          end
        end
`ifdef DMA_ARB_TIMEOUT_EN
        else if (stall_hit) begin
          state_next = TERM;
        end
`endif
      end
`ifdef DMA_ARB_TIMEOUT_EN
      TERM: begin
        if (slot_free) begin
          ld_valid   = 1'b1;
          ld_data    = '0;
          ld_done    = 1'b1;
          ld_err     = 1'b1;
          frame_inc  = 1'b1;
          term_inc   = 1'b1;
          state_next = IDLE;
        end
      end
`endif
      default: state_next = IDLE;
    endcase
  end

  // State and grant register; grant doubles as last_grant between frames.
  always_ff @(posedge dmaClk) begin
    if (dmaRst) begin
      state <= IDLE;
      grant <= GW'(NUM_SRC - 1);
    end else begin
      state <= state_next;
      grant <= grant_next;
    end
  end

  // Output register: holds its beat while downstream stalls.
  always_ff @(posedge dmaClk) begin
    if (dmaRst) begin
      dma_valid <= 1'b0;
      dma_data  <= '0;
      dma_done  <= 1'b0;
      dma_dest  <= '0;
`ifdef DMA_ARB_TIMEOUT_EN
      err_q     <= 1'b0;
`endif
    end else if (slot_free) begin
      dma_valid <= ld_valid;
      if (ld_valid) begin
        dma_data <= ld_data;
        dma_done <= ld_done;
        dma_dest <= 8'(grant);
`ifdef DMA_ARB_TIMEOUT_EN
        err_q    <= ld_err;
`endif
      end
    end
  end

  // Completed-frame counter, wrapping.
  always_ff @(posedge dmaClk) begin
    if (dmaRst) frame_count <= '0;
    else if (frame_inc) frame_count <= frame_count + 32'd1;
  end

`ifdef DMA_ARB_TIMEOUT_EN
  // Stall counter: counts granted-source idle cycles, cleared on any accept.
  always_ff @(posedge dmaClk) begin
    if (dmaRst || state != XFER || accept) stall_cnt <= '0;
    else if (!cur_valid) stall_cnt <= stall_cnt + 1'b1;
  end

  // Forced-termination counter, saturating.
  always_ff @(posedge dmaClk) begin
    if (dmaRst) tcnt_q <= '0;
    else if (term_inc && tcnt_q != 16'hFFFF) tcnt_q <= tcnt_q + 16'd1;
  end
`endif

endmodule

// File: doc/dma_ib_arbiter.md
# dma_ib_arbiter

Frame-atomic round-robin arbiter that shares the single 64-bit inbound DMA stream (DMA0 inbound) between several event sources: the DAQ event builder plus future sources such as a fast-control tag stream or a link monitor. It sits between the sources and the top-level DMA inbound master port. It tags each frame with its source index in tDest and keeps frame and timeout statistics for the AXI-Lite register map.

## Interface
Parameters:
- NUM_SRC, 2, number of requesting sources (2..8)
- TIMEOUT, 4096, source-stall cycles before a frame is force-terminated (only used with the timeout feature)

Ports:
- dmaClk  in  1  DMA clock; sole clock of the block
- dmaRst  in  1  synchronous, active-high reset
- src_valid  in  NUM_SRC  per-source beat valid
- src_data  in  64*NUM_SRC  per-source beat data; source i occupies bits [64i+63:64i]
- src_done  in  NUM_SRC  per-source last beat of frame
- src_ready  out  NUM_SRC  per-source beat accept
- enable_mask  in  NUM_SRC  source i eligible for grant when bit i = 1
- dma_valid  out  1  to dmaIbMaster_tValid
- dma_data  out  64  to dmaIbMaster_tData
- dma_done  out  1  to dmaIbMaster_tLast
- dma_dest  out  8  to dmaIbMaster_tDest; zero-extended source index
- dma_err  out  1  to dmaIbMaster_tUser[0]
- dma_ready  in  1  from dmaIbSlave_tReady
- grant_idx  out  3  index of current or last granted source
- busy  out  1  high in every state except IDLE
- frame_count  out  32  frames completed, wrapping
- timeout_count  out  16  forced terminations, saturating at 0xFFFF

## Operation
- FSM states: IDLE, XFER, TERM.
- Output stage: one register holding valid, data, done, dest and err.
  - The register loads when it is empty (dma_valid = 0) or when dma_ready = 1.
  - slot_free = ~dma_valid | dma_ready.
- **IDLE**
  - Request vector req = src_valid & enable_mask.
  - Search req starting at (last_grant+1) mod NUM_SRC, wrapping.
  - On the first hit: latch grant, go to XFER.
  - If req = 0: stay in IDLE.
- **XFER**
  - src_ready[grant] = src_valid[grant] & slot_free. All other src_ready bits are 0.
  - An accepted beat loads the output register with the source's data and done, dest = grant, err = 0.
  - When the accepted beat has done = 1:
    - frame_count += 1
    - last_grant <= grant
    - go to IDLE
- enable_mask affects only new grants. Clearing the granted source's bit mid-frame does not cut the frame.
- src_done is sampled only together with an accepted beat.
- Reset clears the FSM to IDLE, last_grant to NUM_SRC-1 (so source 0 wins first), all counters, and the output register.
  - A reset mid-frame truncates the frame. Downstream does not receive a tLast for it.
- TERM is reachable only with DMA_ARB_TIMEOUT_EN (see Configuration).

## Timing
- Reset values: dma_valid 0, dma_data 0, dma_done 0, dma_dest 0, dma_err 0, src_ready 0, busy 0, grant_idx NUM_SRC-1, frame_count 0, timeout_count 0.
- Grant latency, with dma_ready held high:
  - src_valid seen in IDLE at cycle 0.
  - Grant registered at cycle 1; src_ready is high in cycle 1.
  - First beat appears on dma_valid in cycle 2.
- Throughput: one beat per cycle while the source is valid and dma_ready = 1.
- Frame gap: one IDLE cycle after each last beat. Back-to-back frames therefore lose one cycle on dma_valid.
- Downstream stall: dma_valid, dma_data, dma_done, dma_dest and dma_err stay stable while dma_valid = 1 and dma_ready = 0. src_ready stays low during the stall.
- Single-beat frame (valid and done in the same cycle) is legal and completes in XFER in one accepted cycle.
- Simultaneous requests are resolved by round-robin order only; there is no fixed priority.

## Configuration
Macro: `DMA_ARB_TIMEOUT_EN`.

Defined:
- A stall counter runs in XFER while src_valid[grant] = 0. It resets on any accepted beat.
- When the counter reaches TIMEOUT, the FSM enters TERM.
- TERM:
  - Waits for slot_free, then loads one beat: data 0, done 1, err 1, dest = grant.
  - timeout_count increments (saturating), frame_count increments, last_grant <= grant.
  - Goes to IDLE.
- Beats the timed-out source sends later are arbitrated as a new frame.

Undefined:
- No stall counter and no TERM state.
- dma_err = 0 and timeout_count = 0 constantly.
- A stalled source holds the grant indefinitely.

## Test plan
- **Basic frame.** Reset, enable_mask = 2'b11, source 0 sends a 4-beat frame 0x1..0x4, dma_ready = 1.
  - dma_valid rises 2 cycles after src_valid, beats 0x1..0x4, dma_done on 0x4.
  - dma_dest = 0, frame_count = 1.
- **Round-robin fairness.** Both sources hold 3-beat frames continuously.
  - Grant order is 0,1,0,1.
  - No interleaving of beats from different sources within a frame.
  - One idle cycle between frames; frame_count = 4 after four frames.
- **Backpressure.** dma_ready toggles 1,0,0,1 during a 5-beat frame.
  - Outputs stay stable while stalled; no beats lost or duplicated.
  - src_ready is low in every stalled cycle.
- **Mask.** enable_mask = 2'b10 with both sources valid: only source 1 is granted.
  - Clear bit 1 mid-frame: that frame still completes with dma_done.
- **Reset mid-frame.** Assert dmaRst during beat 2 of a frame.
  - Next cycle dma_valid = 0, busy = 0, frame_count = 0.
  - The next frame starts from source 0.
- **Timeout** (DMA_ARB_TIMEOUT_EN, TIMEOUT = 16). Source 1 sends 2 beats, then drops src_valid.
  - 16 cycles later a beat appears with data 0, dma_done 1, dma_err 1, dma_dest 1.
  - timeout_count = 1; source 0 is granted next.
